stereo_frame_sequencer: RTL and testbench

Frame-level initiator for the stereo left/right processing pipeline. Drives the per-channel `l_clear`/`r_clear` and `l_start`/`r_start` controls of the pipeline top and collects its per-channel completion strobes. Sequences one frame per request, or runs frames back-to-back. Counts completed frames, measures left/right completion skew, and flags channels that never finish.

---
 rtl/stereo_frame_sequencer.sv | 125 ++++++++++++
 tb/tb_stereo_frame_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_frame_sequencer.sv
// stereo_frame_sequencer: frame-level initiator for the L/R pipeline.
// Clears, starts, waits for both channel dones, tracks skew and timeouts.
module stereo_frame_sequencer #(
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 6000000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             single,
  input  logic             l_done,
  input  logic             r_done,
  output logic             l_clear,
  output logic             r_clear,
  output logic             l_start,
  output logic             r_start,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] done_skew,
  output logic             timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0]       CLR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [23:0]      TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [7:0]       clr_cnt;
  logic [23:0]      timer;
  logic             l_seen;
  logic             r_seen;
  logic             l_seen_nx;
  logic             r_seen_nx;
  logic             both;
  logic             tmo_hit;
  logic [CNT_W-1:0] skew;
  logic [CNT_W-1:0] skew_nx;

  // Sticky done capture, skew step and timeout detect for the WAIT state
  always_comb begin
    l_seen_nx = l_seen | l_done;
    r_seen_nx = r_seen | r_done;
    both      = l_seen_nx & r_seen_nx;
    tmo_hit   = (timer == TMO_LAST);
    skew_nx   = skew;
    if ((l_seen ^ r_seen) && (skew != '1))
      skew_nx = skew + ONE;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (single || run) state_nx = S_CLEAR;
      S_CLEAR: if (clr_cnt == CLR_LAST) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (both)         state_nx = S_DONE;
        else if (tmo_hit) state_nx = S_IDLE;
      end
      S_DONE:  state_nx = run ? S_CLEAR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Frame datapath: clear timing, done flags, timer, skew, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt     <= '0;
      timer       <= '0;
      l_seen      <= 1'b0;
      r_seen      <= 1'b0;
      skew        <= '0;
      frame_cnt   <= '0;
      done_skew   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nx == S_CLEAR)
        timeout_err <= 1'b0;
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 8'd1 : 8'd0;
      if (state == S_START) begin
        l_seen <= 1'b0;
        r_seen <= 1'b0;
        timer  <= '0;
        skew   <= '0;
      end
      if (state == S_WAIT) begin
        l_seen <= l_seen_nx;
        r_seen <= r_seen_nx;
        skew   <= skew_nx;
        timer  <= timer + 24'd1;
        if (both) begin
          done_skew <= skew_nx;
          frame_cnt <= frame_cnt + ONE;
        end else if (tmo_hit) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  // Moore decode of the control outputs
  assign l_clear    = (state == S_CLEAR);
  assign r_clear    = (state == S_CLEAR);
  assign l_start    = (state == S_START);
  assign r_start    = (state == S_START);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// tb_stereo_frame_sequencer: vectors, corner sequences and random traffic
// against an arrival-time reference model; second DUT has a 4-bit counter.
module tb_stereo_frame_sequencer;

  localparam int CC = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst, run, single, l_done, r_done;
  logic l_clear, r_clear, l_start, r_start;
  logic busy, frame_done, timeout_err;
  logic [15:0] frame_cnt, done_skew;
  logic w_l_clear, w_r_clear, w_l_start, w_r_start;
  logic w_busy, w_frame_done, w_timeout_err;
  logic [3:0] w_cnt, w_skew;

  int n_cmp = 0;
  int n_bad = 0;

  stereo_frame_sequencer #(
    .CLEAR_CYCLES(CC), .TIMEOUT_CYCLES(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .single(single),
    .l_done(l_done), .r_done(r_done),
    .l_clear(l_clear), .r_clear(r_clear),
    .l_start(l_start), .r_start(r_start),
    .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .done_skew(done_skew),
    .timeout_err(timeout_err)
  );

  stereo_frame_sequencer #(
    .CLEAR_CYCLES(CC), .TIMEOUT_CYCLES(TO), .CNT_W(4)
  ) dut_w (
    .clk(clk), .rst(rst), .run(run), .single(single),
    .l_done(l_done), .r_done(r_done),
    .l_clear(w_l_clear), .r_clear(w_r_clear),
    .l_start(w_l_start), .r_start(w_r_start),
    .busy(w_busy), .frame_done(w_frame_done),
    .frame_cnt(w_cnt), .done_skew(w_skew),
    .timeout_err(w_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h expected %0h",
               name, $time, got, exp);
    end
  endtask

  // Reference model: frame position, done arrival times, counters
  int m_pos, m_cnt, m_skew, m_lt, m_rt, m_w;
  bit m_fd, m_err;
  bit m_ok = 1'b0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [6:0] exp_ctl();
    logic c, s;
    c = (m_pos >= 0) && (m_pos < CC);
    s = (m_pos == CC);
    return {c, c, s, s, m_pos != -1, m_fd, m_err};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pos = -1; m_fd = 0; m_err = 0;
      m_cnt = 0; m_skew = 0; m_ok = 1;
    end else if (m_fd) begin
      m_fd  = 0;
      m_pos = run ? 0 : -1;
    end else if (m_pos == -1) begin
      if (single || run) begin
        m_pos = 0;
        m_err = 0;
      end
    end else if (m_pos < CC) begin
      m_pos++;
    end else if (m_pos == CC) begin
      m_pos = CC + 1;
      m_lt = -1; m_rt = -1; m_w = 0;
    end else begin
      if (l_done && m_lt < 0) m_lt = m_w;
      if (r_done && m_rt < 0) m_rt = m_w;
      if (m_lt >= 0 && m_rt >= 0) begin
        m_fd   = 1;
        m_pos  = -2;
        m_cnt++;
        m_skew = (m_lt > m_rt) ? m_lt - m_rt : m_rt - m_lt;
      end else if (m_w == TO - 1) begin
        m_err = 1;
        m_pos = -1;
      end else begin
        m_w++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_ctl",
          64'({l_clear, r_clear, l_start, r_start,
               busy, frame_done, timeout_err}),
          64'(exp_ctl()));
      chk("model_cnt", 64'(frame_cnt), 64'(m_cnt % 65536));
      chk("model_skew", 64'(done_skew), 64'(sat(m_skew, 65535)));
      chk("model_w_ctl",
          64'({w_l_clear, w_r_clear, w_l_start, w_r_start,
               w_busy, w_frame_done, w_timeout_err}),
          64'(exp_ctl()));
      chk("model_w_cnt", 64'(w_cnt), 64'(m_cnt % 16));
      chk("model_w_skew", 64'(w_skew), 64'(sat(m_skew, 15)));
    end
  end

  typedef struct {
    logic [4:0] in;
    logic [4:0] out;
    int cnt;
    int skew;
  } vec_t;

  vec_t tv[12];

  task automatic cyc(input logic s, input logic r,
                     input logic l, input logic d);
    single = s; run = r; l_done = l; r_done = d;
    @(negedge clk);
  endtask

  task automatic wait_start();
    int n = 0;
    single = 0; l_done = 0; r_done = 0;
    while (!l_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!l_start) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_start: start 0 after 40 cycles, need 1");
    end
  endtask

  initial begin
    int st_q[$];
    int cycn, nfd;
    bit pst, ld;

    // inputs {rst,single,run,l_done,r_done}
    // outputs {clear,start,busy,frame_done,timeout_err}
    tv[0]  = '{5'b10000, 5'b00000, 0, 0};
    tv[1]  = '{5'b10000, 5'b00000, 0, 0};
    tv[2]  = '{5'b01000, 5'b10100, 0, 0};
    tv[3]  = '{5'b00000, 5'b10100, 0, 0};
    tv[4]  = '{5'b00000, 5'b01100, 0, 0};
    tv[5]  = '{5'b00000, 5'b00100, 0, 0};
    tv[6]  = '{5'b00000, 5'b00100, 0, 0};
    tv[7]  = '{5'b00000, 5'b00100, 0, 0};
    tv[8]  = '{5'b00000, 5'b00100, 0, 0};
    tv[9]  = '{5'b00011, 5'b00110, 1, 0};
    tv[10] = '{5'b00000, 5'b00000, 1, 0};
    tv[11] = '{5'b00000, 5'b00000, 1, 0};

    for (int i = 0; i < 12; i++) begin
      {rst, single, run, l_done, r_done} = tv[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({l_clear, r_clear, l_start, r_start, busy,
               frame_done, timeout_err, frame_cnt, done_skew}),
          64'({tv[i].out[4], tv[i].out[4], tv[i].out[3],
               tv[i].out[3], tv[i].out[2], tv[i].out[1],
               tv[i].out[0], 16'(tv[i].cnt), 16'(tv[i].skew)}));
    end

    // left first, right 5 cycles later
    cyc(1, 0, 0, 0);
    wait_start();
    @(negedge clk);
    cyc(0, 0, 1, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("skew5_fd", 64'(frame_done), 64'(1));
    chk("skew5", 64'(done_skew), 64'(5));
    cyc(0, 0, 0, 0);

    // right first, left 3 cycles later
    cyc(1, 0, 0, 0);
    wait_start();
    @(negedge clk);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("skew3", 64'(done_skew), 64'(3));
    cyc(0, 0, 0, 0);

    // 17-cycle gap saturates the 4-bit skew
    cyc(1, 0, 0, 0);
    wait_start();
    @(negedge clk);
    cyc(0, 0, 1, 0);
    repeat (16) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("skew17", 64'(done_skew), 64'(17));
    chk("skew_sat", 64'(w_skew), 64'(15));
    cyc(0, 0, 0, 0);

    // only left answers: timeout
    cyc(1, 0, 0, 0);
    wait_start();
    @(negedge clk);
    cyc(0, 0, 1, 0);
    repeat (19) cyc(0, 0, 0, 0);
    chk("tmo_err", 64'(timeout_err), 64'(1));
    chk("tmo_busy", 64'(busy), 64'(0));
    chk("tmo_cnt", 64'(frame_cnt), 64'(4));
    chk("tmo_skew", 64'(done_skew), 64'(17));

    // new request clears error; dones held over CLEAR/START ignored
    cyc(1, 0, 0, 0);
    chk("err_clr", 64'(timeout_err), 64'(0));
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    chk("early_done", 64'({busy, frame_done}), 64'(2'b10));
    // single during WAIT is not queued
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 1);
    chk("late_fd", 64'(frame_done), 64'(1));
    cyc(0, 0, 0, 0);
    chk("no_queue", 64'(busy), 64'(0));
    chk("cnt5", 64'(frame_cnt), 64'(5));

    // run mode with immediate answers: minimum period
    pst = 0;
    cycn = 0;
    for (int i = 0; i < 30; i++) begin
      if (l_start) st_q.push_back(cycn);
      ld = pst;
      pst = l_start;
      cyc(0, 1, ld, ld);
      cycn++;
    end
    for (int i = 1; i < 4; i++)
      chk($sformatf("period%0d", i),
          64'(st_q[i] - st_q[i-1]), 64'(CC + 3));

    // drop run mid-frame: frame completes, then idle
    wait_start();
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 1);
    chk("drop_fd", 64'(frame_done), 64'(1));
    cyc(0, 0, 0, 0);
    chk("drop_idle", 64'(busy), 64'(0));

    // reset in WAIT
    cyc(1, 0, 0, 0);
    wait_start();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_wait",
        64'({l_clear, r_clear, l_start, r_start, busy,
             frame_done, timeout_err, frame_cnt, done_skew}),
        64'(0));
    chk("rst_wait_w",
        64'({w_busy, w_frame_done, w_cnt, w_skew}), 64'(0));
    rst = 0;

    // 16 frames: 4-bit counter wraps to 0
    pst = 0;
    nfd = 0;
    for (int i = 0; i < 200 && nfd < 16; i++) begin
      if (frame_done) begin
        nfd++;
        if (nfd == 16) begin
          chk("wrap_cnt", 64'(w_cnt), 64'(0));
          chk("wrap_fd", 64'(w_frame_done), 64'(1));
          chk("cnt16", 64'(frame_cnt), 64'(16));
        end
      end
      if (nfd < 16) begin
        ld = pst;
        pst = l_start;
        cyc(0, 1, ld, ld);
      end
    end
    if (nfd < 16) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap: %0d frames seen, need 16", nfd);
    end
    repeat (12) cyc(0, 0, 0, 0);

    // random traffic against the model
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 399) == 0);
      single = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) run = ~run;
      l_done = ($urandom_range(0, 4) == 0);
      r_done = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end
    rst = 0;
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
